// File: rtl/approx_adder_pipe_mon.sv
// approx_adder_pipe_mon: two-stage pipelined lower-part-OR approximate adder
// with per-result error reporting and saturating consumption statistics.
module approx_adder_pipe_mon #(
  parameter int W     = 2,
  parameter int LPP   = 1,
  parameter int ET    = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W:0]       out_sum,
  output logic [W:0]       out_err,
  output logic             out_viol,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] stat_total,
  output logic [CNT_W-1:0] stat_viol,
  output logic [W:0]       stat_max_err
);

  localparam logic [31:0] ET_U = 32'(ET);

  // vld_pipe[1] = S1 occupied, vld_pipe[2] = S2 occupied (drives out_valid)
  logic [2:1]   vld_pipe;
  logic         rdy_en;
  logic         s1_free, adv2, acc, hs;

  logic         s1_mode;
  logic [W:0]   s1_exact, s1_approx;

  logic [W:0]   exact_c, approx_c;
  logic [W:0]   sel_c, err_c;
  logic         viol_c;

  // S1 can take a new pair when empty or when its entry moves into S2 this cycle
  assign s1_free  = !vld_pipe[1] | !vld_pipe[2] | out_ready;
  assign adv2     = vld_pipe[1] & (!vld_pipe[2] | out_ready);
  assign in_ready = rdy_en & s1_free;
  assign acc      = in_valid & in_ready;
  assign hs       = vld_pipe[2] & out_ready;
  assign out_valid = vld_pipe[2];

  assign exact_c = {1'b0, in_a} + {1'b0, in_b};

  // Approximate sum: low LPP bits ORed, carry into the exact upper part
  // taken as the AND of the top approximated bits.
  generate
    if (LPP == 0) begin : g_exact
      assign approx_c = exact_c;
    end else if (LPP == W) begin : g_all_or
      assign approx_c = {in_a[W-1] & in_b[W-1], in_a | in_b};
    end else begin : g_mix
      logic          c;
      logic [W-LPP:0] hi;
      assign c  = in_a[LPP-1] & in_b[LPP-1];
      assign hi = {1'b0, in_a[W-1:LPP]} + {1'b0, in_b[W-1:LPP]}
                + {{(W-LPP){1'b0}}, c};
      assign approx_c = {hi, in_a[LPP-1:0] | in_b[LPP-1:0]};
    end
  endgenerate

  // Stage-2 combinational selection and error magnitude
  always_comb begin
    sel_c = s1_mode ? s1_approx : s1_exact;
    err_c = '0;
    if (s1_mode)
      err_c = (s1_approx >= s1_exact) ? (s1_approx - s1_exact)
                                      : (s1_exact - s1_approx);
    viol_c = 32'(err_c) > ET_U;
  end

  // in_ready stays low through reset and rises one cycle after release
  always_ff @(posedge clk) begin
    if (rst) rdy_en <= 1'b0;
    else     rdy_en <= 1'b1;
  end

  // Stage 1: capture mode plus both candidate sums on input handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe[1] <= 1'b0;
      s1_mode     <= 1'b0;
      s1_exact    <= '0;
      s1_approx   <= '0;
    end else begin
      if (s1_free) vld_pipe[1] <= acc;
      if (acc) begin
        s1_mode   <= mode;
        s1_exact  <= exact_c;
        s1_approx <= approx_c;
      end
    end
  end

  // Stage 2: result registers, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe[2] <= 1'b0;
      out_sum     <= '0;
      out_err     <= '0;
      out_viol    <= 1'b0;
    end else begin
      if (!vld_pipe[2] | out_ready) vld_pipe[2] <= vld_pipe[1];
      if (adv2) begin
        out_sum  <= sel_c;
        out_err  <= err_c;
        out_viol <= viol_c;
      end
    end
  end

  // Statistics on output handshake; clr_stats wins over a same-cycle update
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      stat_total   <= '0;
      stat_viol    <= '0;
      stat_max_err <= '0;
    end else if (hs) begin
      if (stat_total != '1) stat_total <= stat_total + 1'b1;
      if (out_viol && stat_viol != '1) stat_viol <= stat_viol + 1'b1;
      if (out_err > stat_max_err) stat_max_err <= out_err;
    end
  end

endmodule
